// File: rtl/stack_pkg.sv
// Shared types and constants for the block-stacking game engine.
// Holds the FSM state encoding, box palette and screen geometry.
package stack_pkg;

  typedef enum logic [2:0] {
    ST_SWING,
    ST_DROP,
    ST_CHECK,
    ST_FALL,
    ST_CLEAR,
    ST_OVER
  } state_e;

  localparam int SCREEN_W = 640;
  localparam int REFR_ROW = 481;
  localparam logic [11:0] FLOOR_RGB = 12'hC30;

  // Entry 0 is the rightmost element of the packed list.
  localparam logic [7:0][11:0] PALETTE = {
    12'hFFF, 12'hF80, 12'h0FF, 12'hF0F,
    12'hFF0, 12'h00F, 12'h0F0, 12'hF00
  };

endpackage

// File: rtl/stack_box_hit.sv
// Combinational square hit test: is (pix_x, pix_y) inside the box at (box_x, box_y)?
// Pure logic, no latency.
module stack_box_hit (
  input  logic [9:0] box_x,
  input  logic [9:0] box_y,
  input  logic [9:0] box_size,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       hit
);

  logic [10:0] x_end;
  logic [10:0] y_end;

  assign x_end = {1'b0, box_x} + {1'b0, box_size};
  assign y_end = {1'b0, box_y} + {1'b0, box_size};

  assign hit = (pix_x >= box_x) && ({1'b0, pix_x} < x_end) &&
               (pix_y >= box_y) && ({1'b0, pix_y} < y_end);

endmodule

// File: rtl/stack_game_engine.sv
// Swing/drop/land/stack game FSM with frame-rate motion and a registered pixel renderer.
// Motion advances once per refresh tick; graph_rgb lags pix_x/pix_y by one clock.
module stack_game_engine
  import stack_pkg::*;
#(
  parameter int NUM_BOXES  = 5,
  parameter int BASE_SIZE  = 72,
  parameter int SIZE_STEP  = 12,
  parameter int BASE_SPEED = 2,
  parameter int SPEED_STEP = 1,
  parameter int DROP_SPEED = 3,
  parameter int FLOOR_Y    = 450
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        drop,
  input  logic        restart,
  output logic [11:0] graph_rgb,
  output logic [3:0]  level,
  output logic [3:0]  stack_count,
  output logic        win,
  output logic        game_over
);

  if (NUM_BOXES < 2 || NUM_BOXES > 8 ||
      BASE_SIZE - (NUM_BOXES - 1) * SIZE_STEP < 8) begin : g_param_check
    $error("stack_game_engine: NUM_BOXES/BASE_SIZE/SIZE_STEP out of range");
  end

  function automatic logic [9:0] box_size(input logic [2:0] i);
    return 10'(BASE_SIZE - int'(i) * SIZE_STEP);
  endfunction

  // Top row of landed box i: floor minus the heights of boxes 0..i.
  function automatic int land_y(input int i);
    int top;
    top = FLOOR_Y;
    for (int j = 0; j <= i; j++) top -= BASE_SIZE - j * SIZE_STEP;
    return top;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        dir_q, dir_d;
  logic [9:0]  stack_top_q, stack_top_d;
  logic [3:0]  stack_count_q, stack_count_d;
  logic [3:0]  level_q, level_d;
  logic        win_q, win_d;
  logic        over_q, over_d;
  logic        drop_pend_q, drop_pend_d;
  logic [9:0]  land_x_q [NUM_BOXES];
  logic [9:0]  land_x_d [NUM_BOXES];
  logic [11:0] rgb_q, rgb_d;

  logic        refr_tick;
  logic [9:0]  cur_size;
  logic [9:0]  prev_size;
  logic [9:0]  prev_lx;
  logic [9:0]  speed;
  logic [10:0] x_reach;
  logic [9:0]  y_next;
  logic [10:0] y_bottom;
  logic [9:0]  x_right;
  logic [9:0]  prev_right;
  logic        lands;

  assign refr_tick = (pix_y == 10'(REFR_ROW)) && (pix_x == 10'd0);
  assign cur_size  = box_size(idx_q);
  assign prev_size = box_size(idx_q - 3'd1);
  assign speed     = 10'(BASE_SPEED + int'(idx_q) * SPEED_STEP) + {6'd0, level_q} - 10'd1;
  // Eleven bits so the right-edge test cannot wrap.
  assign x_reach   = {1'b0, x_q} + {1'b0, cur_size} - 11'd1 + {1'b0, speed};
  assign y_next    = y_q + 10'(DROP_SPEED);
  assign y_bottom  = {1'b0, y_next} + {1'b0, cur_size};
  assign x_right   = x_q + cur_size - 10'd1;

  always_comb begin
    prev_lx = '0;
    for (int i = 0; i < NUM_BOXES - 1; i++) begin
      if (idx_q == 3'(i + 1)) prev_lx = land_x_q[i];
    end
  end

  assign prev_right = prev_lx + prev_size - 10'd1;
  assign lands      = (idx_q == 3'd0) || ((x_right >= prev_lx) && (x_q <= prev_right));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    x_d           = x_q;
    y_d           = y_q;
    dir_d         = dir_q;
    stack_top_d   = stack_top_q;
    stack_count_d = stack_count_q;
    level_d       = level_q;
    win_d         = win_q;
    over_d        = over_q;
    drop_pend_d   = drop_pend_q;
    land_x_d      = land_x_q;

    if (restart) begin
      if (state_q == ST_CLEAR) begin
        level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
      end else begin
        level_d = 4'd1;
      end
      state_d       = ST_SWING;
      idx_d         = '0;
      x_d           = '0;
      y_d           = '0;
      dir_d         = 1'b1;
      stack_top_d   = 10'(FLOOR_Y);
      stack_count_d = '0;
      win_d         = 1'b0;
      over_d        = 1'b0;
      drop_pend_d   = 1'b0;
      for (int i = 0; i < NUM_BOXES; i++) land_x_d[i] = '0;
    end else begin
      case (state_q)
        ST_SWING: begin
          if (refr_tick && drop_pend_q) begin
            state_d     = ST_DROP;
            drop_pend_d = 1'b0;
          end else begin
            if (drop) drop_pend_d = 1'b1;
            if (refr_tick) begin
              if (dir_q) begin
                if (x_reach > 11'd639) begin
                  x_d   = 10'(SCREEN_W) - cur_size;
                  dir_d = 1'b0;
                end else begin
                  x_d = x_q + speed;
                end
              end else begin
                if (x_q < speed) begin
                  x_d   = '0;
                  dir_d = 1'b1;
                end else begin
                  x_d = x_q - speed;
                end
              end
            end
          end
        end
        ST_DROP: begin
          if (refr_tick) begin
            if (y_bottom >= {1'b0, stack_top_q}) begin
              y_d     = stack_top_q - cur_size;
              state_d = ST_CHECK;
            end else begin
              y_d = y_next;
            end
          end
        end
        ST_CHECK: begin
          if (lands) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
              if (idx_q == 3'(i)) land_x_d[i] = x_q;
            end
            stack_top_d   = stack_top_q - cur_size;
            stack_count_d = stack_count_q + 4'd1;
            if (stack_count_d == 4'(NUM_BOXES)) begin
              state_d = ST_CLEAR;
            end else begin
              idx_d   = idx_q + 3'd1;
              x_d     = '0;
              y_d     = '0;
              dir_d   = 1'b1;
              state_d = ST_SWING;
            end
          end else begin
            state_d = ST_FALL;
          end
        end
        ST_FALL: begin
          if (refr_tick) begin
            if (y_bottom >= 11'(FLOOR_Y)) begin
              y_d     = 10'(FLOOR_Y) - cur_size;
              state_d = ST_OVER;
            end else begin
              y_d = y_next;
            end
          end
        end
        ST_CLEAR: win_d  = 1'b1;
        ST_OVER:  over_d = 1'b1;
        default:  state_d = ST_SWING;
      endcase
    end
  end

  // Index NUM_BOXES is the active box; the others are the landed boxes.
  logic [NUM_BOXES:0] hit;

  for (genvar g = 0; g <= NUM_BOXES; g++) begin : g_hit
    if (g < NUM_BOXES) begin : g_landed
      stack_box_hit u_hit (
        .box_x    (land_x_q[g]),
        .box_y    (10'(land_y(g))),
        .box_size (box_size(3'(g))),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .hit      (hit[g])
      );
    end else begin : g_active
      stack_box_hit u_hit (
        .box_x    (x_q),
        .box_y    (y_q),
        .box_size (cur_size),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .hit      (hit[g])
      );
    end
  end

  logic found;

  always_comb begin
    rgb_d = 12'h000;
    found = 1'b0;
    if (video_on) begin
      if (hit[NUM_BOXES]) begin
        rgb_d = PALETTE[idx_q];
        found = 1'b1;
      end
      for (int i = 0; i < NUM_BOXES; i++) begin
        if (!found && hit[i] && (4'(i) < stack_count_q)) begin
          rgb_d = PALETTE[3'(i)];
          found = 1'b1;
        end
      end
      if (!found && (pix_y >= 10'(FLOOR_Y))) rgb_d = FLOOR_RGB;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_SWING;
      idx_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      dir_q         <= 1'b1;
      stack_top_q   <= 10'(FLOOR_Y);
      stack_count_q <= '0;
      level_q       <= 4'd1;
      win_q         <= 1'b0;
      over_q        <= 1'b0;
      drop_pend_q   <= 1'b0;
      land_x_q      <= '{default: '0};
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dir_q         <= dir_d;
      stack_top_q   <= stack_top_d;
      stack_count_q <= stack_count_d;
      level_q       <= level_d;
      win_q         <= win_d;
      over_q        <= over_d;
      drop_pend_q   <= drop_pend_d;
      land_x_q      <= land_x_d;
      rgb_q         <= rgb_d;
    end
  end

  assign graph_rgb   = rgb_q;
  assign level       = level_q;
  assign stack_count = stack_count_q;
  assign win         = win_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_stack_game_engine.sv
// Directed game scenarios plus random play, scored against a frame-level reference model.
module tb_stack_game_engine;
  import stack_pkg::*;

  localparam int NB  = 5;
  localparam int BS  = 72;
  localparam int SS  = 12;
  localparam int BSP = 2;
  localparam int SPS = 1;
  localparam int DS  = 3;
  localparam int FY  = 450;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        drop;
  logic        restart;
  logic [11:0] graph_rgb;
  logic [3:0]  level;
  logic [3:0]  stack_count;
  logic        win;
  logic        game_over;

  stack_game_engine #(
    .NUM_BOXES(NB), .BASE_SIZE(BS), .SIZE_STEP(SS), .BASE_SPEED(BSP),
    .SPEED_STEP(SPS), .DROP_SPEED(DS), .FLOOR_Y(FY)
  ) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .drop(drop), .restart(restart), .graph_rgb(graph_rgb), .level(level),
    .stack_count(stack_count), .win(win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference game state, one entry per game rule.
  state_e m_st;
  int     m_idx, m_x, m_y, m_dir, m_top, m_cnt, m_level;
  bit     m_win, m_over, m_pend;
  int     m_land [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sz(input int i);
    return BS - i * SS;
  endfunction

  function automatic int top_of(input int j);
    int t;
    t = FY;
    for (int k = 0; k <= j; k++) t -= sz(k);
    return t;
  endfunction

  function automatic bit in_box(input int px, input int py, input int bx, input int by, input int s);
    return px >= bx && px < bx + s && py >= by && py < by + s;
  endfunction

  function automatic int render_exp(input int px, input int py, input bit vo);
    if (!vo) return 0;
    if (in_box(px, py, m_x, m_y, sz(m_idx))) return int'(PALETTE[m_idx % 8]);
    for (int j = 0; j < m_cnt; j++)
      if (in_box(px, py, m_land[j], top_of(j), sz(j))) return int'(PALETTE[j % 8]);
    if (py >= FY) return int'(FLOOR_RGB);
    return 0;
  endfunction

  task automatic model_init(input int lvl);
    m_st = ST_SWING; m_idx = 0; m_x = 0; m_y = 0; m_dir = 1; m_top = FY;
    m_cnt = 0; m_level = lvl; m_win = 0; m_over = 0; m_pend = 0;
    for (int i = 0; i < NB; i++) m_land[i] = 0;
  endtask

  task automatic model_step(input bit d, input bit r, input bit t);
    int s, v, ny, lim;
    s = sz(m_idx);
    v = BSP + m_idx * SPS + m_level - 1;
    if (r) begin
      model_init((m_st == ST_CLEAR) ? ((m_level < 15) ? m_level + 1 : 15) : 1);
    end else begin
      if (m_st == ST_CLEAR) m_win = 1;
      if (m_st == ST_OVER) m_over = 1;
      case (m_st)
        ST_SWING: begin
          if (t && m_pend) begin
            m_st = ST_DROP; m_pend = 0;
          end else begin
            if (d) m_pend = 1;
            if (t && m_dir == 1) begin
              if (m_x + s - 1 + v > 639) begin m_x = 640 - s; m_dir = 0; end
              else m_x = m_x + v;
            end else if (t) begin
              if (m_x - v < 0) begin m_x = 0; m_dir = 1; end
              else m_x = m_x - v;
            end
          end
        end
        ST_DROP, ST_FALL: begin
          if (t) begin
            ny  = m_y + DS;
            lim = (m_st == ST_DROP) ? m_top : FY;
            if (ny + s >= lim) begin
              m_y  = lim - s;
              m_st = (m_st == ST_DROP) ? ST_CHECK : ST_OVER;
            end else m_y = ny;
          end
        end
        ST_CHECK: begin
          bit ok;
          ok = (m_idx == 0);
          if (m_idx > 0)
            ok = (m_x + s - 1 >= m_land[m_idx-1]) && (m_x <= m_land[m_idx-1] + sz(m_idx-1) - 1);
          if (ok) begin
            m_land[m_idx] = m_x; m_top = m_top - s; m_cnt = m_cnt + 1;
            if (m_cnt == NB) m_st = ST_CLEAR;
            else begin m_idx++; m_x = 0; m_y = 0; m_dir = 1; m_st = ST_SWING; end
          end else m_st = ST_FALL;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit d, input bit r, input bit t);
    int e_rgb, s, sel, j;
    @(negedge clk);
    drop = d; restart = r;
    if (t) begin
      pix_x = 10'd0; pix_y = 10'(REFR_ROW); video_on = 1'b0;
    end else begin
      s   = sz(m_idx);
      sel = int'($urandom_range(0, 2));
      if (sel == 1) begin
        pix_x = 10'(m_x + int'($urandom_range(0, s - 1)));
        pix_y = 10'(m_y + int'($urandom_range(0, s - 1)));
      end else if (sel == 2 && m_cnt > 0) begin
        j = int'($urandom_range(0, m_cnt - 1));
        pix_x = 10'(m_land[j] + int'($urandom_range(0, sz(j) - 1)));
        pix_y = 10'(top_of(j) + int'($urandom_range(0, sz(j) - 1)));
      end else begin
        pix_x = 10'($urandom_range(0, 639));
        pix_y = 10'($urandom_range(0, 479));
      end
      video_on = ($urandom_range(0, 7) != 0);
    end
    @(posedge clk);
    e_rgb = render_exp(int'(pix_x), int'(pix_y), video_on);
    model_step(d, r, t);
    #1;
    chk("rgb", 32'(graph_rgb), e_rgb);
    chk("x", 32'(dut.x_q), m_x);
    chk("y", 32'(dut.y_q), m_y);
    chk("level", 32'(level), m_level);
    chk("stack_count", 32'(stack_count), m_cnt);
    chk("win", 32'(win), 32'(m_win));
    chk("game_over", 32'(game_over), 32'(m_over));
    chk("x_in_range", 32'(int'(dut.x_q) + sz(int'(dut.idx_q)) <= 640), 1);
  endtask

  task automatic frame();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_x(input int target);
    int n;
    n = 0;
    while (!(m_st == ST_SWING && m_dir == 1 && m_x >= target) && n < 3000) begin
      frame(); n++;
    end
    chk("reach_target", 32'(n < 3000), 1);
  endtask

  task automatic drop_at(input int target);
    int n;
    wait_x(target);
    cyc(1'b1, 1'b0, 1'b0);
    n = 0;
    do begin frame(); n++; end
    while ((m_st inside {ST_DROP, ST_CHECK, ST_FALL}) && n < 3000);
    chk("settle", 32'(n < 3000), 1);
  endtask

  task automatic check_reset_values();
    chk("rst_rgb", 32'(graph_rgb), 0);
    chk("rst_level", 32'(level), 1);
    chk("rst_count", 32'(stack_count), 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_x", 32'(dut.x_q), 0);
    chk("rst_y", 32'(dut.y_q), 0);
    chk("rst_idx", 32'(dut.idx_q), 0);
    chk("rst_pend", 32'(dut.drop_pend_q), 0);
    chk("rst_top", 32'(dut.stack_top_q), FY);
  endtask

  int  tops [NB] = '{378, 318, 270, 234, 210};
  bit  seen_hi, seen_lo;
  bit  rd, rr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; drop = 1'b0; restart = 1'b0; video_on = 1'b0;
    pix_x = 10'd0; pix_y = 10'd0;
    model_init(1);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b1;

    // Free-running bounce of box 0.
    seen_hi = 0; seen_lo = 0;
    for (int i = 0; i < 600; i++) begin
      frame();
      if (dut.x_q == 10'd568) seen_hi = 1;
      if (seen_hi && dut.x_q == 10'd0) seen_lo = 1;
    end
    chk("bounce_hits_568", 32'(seen_hi), 1);
    chk("bounce_hits_0", 32'(seen_lo), 1);

    // Box 0 at x=100, then box 1 misses to the right.
    drop_at(100);
    chk("land0_top", 32'(dut.stack_top_q), 378);
    chk("land0_count", 32'(stack_count), 1);
    chk("spawn1_x", 32'(dut.x_q), 0);
    chk("spawn1_y", 32'(dut.y_q), 0);
    frame();
    chk("box1_speed", 32'(dut.x_q), 3);
    drop_at(200);
    chk("miss_x", 32'(dut.x_q), 201);
    chk("miss_y", 32'(dut.y_q), 390);
    chk("miss_over", 32'(game_over), 1);
    chk("miss_level", 32'(level), 1);
    cyc(1'b1, 1'b0, 1'b0);
    frame();
    chk("over_ignores_drop", 32'(dut.y_q), 390);
    cyc(1'b0, 1'b1, 1'b0);
    chk("restart_over_level", 32'(level), 1);
    chk("restart_over_flag", 32'(game_over), 0);

    // Five aligned drops clear the level.
    for (int k = 0; k < NB; k++) begin
      drop_at(300);
      chk("aligned_top", 32'(dut.stack_top_q), tops[k]);
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk("win_flag", 32'(win), 1);
    chk("win_count", 32'(stack_count), NB);
    cyc(1'b0, 1'b1, 1'b0);
    chk("next_level", 32'(level), 2);
    frame();
    chk("level2_speed", 32'(dut.x_q), 3);

    // Restart and drop together mid-game.
    drop_at(300);
    frame();
    cyc(1'b1, 1'b1, 1'b0);
    chk("rd_pend", 32'(dut.drop_pend_q), 0);
    chk("rd_idx", 32'(dut.idx_q), 0);
    chk("rd_level", 32'(level), 1);
    frame();
    chk("rd_moves", 32'(dut.x_q), 2);

    // Reset while box 2 is falling onto the stack.
    drop_at(300);
    drop_at(300);
    wait_x(300);
    cyc(1'b1, 1'b0, 1'b0);
    frame();
    frame();
    chk("drop2_y", 32'(dut.y_q), 3);
    @(negedge clk);
    reset = 1'b0; drop = 1'b0; restart = 1'b0; video_on = 1'b0;
    #1;
    model_init(1);
    check_reset_values();
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b1;
    frame();
    chk("resume_x", 32'(dut.x_q), 2);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      rd = ($urandom_range(0, 11) == 0);
      if (m_st inside {ST_CLEAR, ST_OVER}) rr = ($urandom_range(0, 9) == 0);
      else rr = ($urandom_range(0, 499) == 0);
      cyc(rd, rr, (i % 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
